// File: rtl/song_sequencer.sv
// song_sequencer: auto-play note sequencer that walks an external song ROM
// and emits timed note codes plus a one-hot LED pattern for the Buzzer.
module song_sequencer #(
  parameter int TICK_DIV  = 12_500_000,
  parameter int GAP_TICKS = 1,
  parameter int NUM_SONGS = 4,
  parameter int STEP_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play_en,
  input  logic [1:0]        song_select,
  output logic [STEP_W+1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [3:0]        note_out,
  output logic [6:0]        led_out,
  output logic [1:0]        song_idx,
  output logic              playing
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int NW = $clog2((GAP_TICKS > 15 ? GAP_TICKS : 15) + 1);
  typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;
  state_t state, state_nx;
  logic [1:0] sel_q, rise;
  logic [STEP_W-1:0] step;
  logic [3:0] note, dur;
  logic [TW-1:0] tcnt;
  logic [NW-1:0] tn;
  logic done, nxt, prv, chg, tick_end, play_done, gap_done, entry;
  assign rise      = song_select & ~sel_q;
  assign nxt       = rise == 2'b01;
  assign prv       = rise == 2'b10;
  assign chg       = nxt | prv;
  assign tick_end  = tcnt == TW'(TICK_DIV - 1);
  assign play_done = tick_end && tn == NW'(dur - 4'd1);
  assign gap_done  = tick_end && tn == NW'(GAP_TICKS - 1);
  assign entry     = state_nx != state;
  assign rom_addr  = {song_idx, step};
  assign playing   = state != IDLE;
  assign note_out  = state == PLAY ? note : 4'd0;
  assign led_out   = (note_out == 4'd0 || note_out == 4'd15) ? 7'd0 :
                     7'd1 << (note_out > 4'd7 ? note_out - 4'd8 : note_out - 4'd1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state != IDLE && !play_en) state_nx = IDLE;
    else if (state != IDLE && chg) state_nx = FETCH;
    else
      case (state)
        IDLE:  state_nx = (play_en && !done) ? FETCH : IDLE;
        FETCH: state_nx = rom_data[3:0] == 4'd0 ? IDLE : PLAY;
        PLAY:  state_nx = play_done ? GAP : PLAY;
        GAP:   state_nx = gap_done ? (&step ? IDLE : FETCH) : GAP;
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel_q    <= '0;
      song_idx <= '0;
      step     <= '0;
      note     <= '0;
      dur      <= '0;
      tcnt     <= '0;
      tn       <= '0;
      done     <= 1'b0;
    end else begin
      sel_q <= song_select;
      if (nxt) song_idx <= song_idx == 2'(NUM_SONGS - 1) ? 2'd0 : song_idx + 2'd1;
      else if (prv) song_idx <= song_idx == 2'd0 ? 2'(NUM_SONGS - 1) : song_idx - 2'd1;
      if (chg || (state != IDLE && state_nx == IDLE)) step <= '0;
      else if (state == GAP && state_nx == FETCH) step <= step + STEP_W'(1);
      if (state == FETCH) {note, dur} <= rom_data;
      // tick counters only run inside PLAY/GAP and restart on every state entry
      tcnt <= (entry || !(state == PLAY || state == GAP) || tick_end) ? '0 : tcnt + TW'(1);
      tn   <= (entry || !(state == PLAY || state == GAP)) ? '0 : tick_end ? tn + NW'(1) : tn;
      // a natural song end blocks restart until play_en is dropped
      done <= play_en && (done || (state != IDLE && state_nx == IDLE));
    end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: randomized bench comparing the sequencer against a
// per-song expected output stream built from the ROM contents.
module tb_song_sequencer;
  localparam int TD = 4;
  localparam int GT = 1;
  logic clk = 1'b0, rst_n, play_en;
  logic [1:0] song_select, song_idx;
  logic [6:0] rom_addr, led_out;
  logic [7:0] rom_data;
  logic [3:0] note_out;
  logic playing;
  logic [7:0] rom [128];
  int n_pass = 0, n_total = 0;
  typedef struct packed {logic [3:0] note; logic ply; logic [4:0] st;} ev_t;
  ev_t q[$];
  ev_t exp_e;
  int m_song;
  bit m_done, last_ply;
  logic [1:0] prev_sel;

  song_sequencer #(.TICK_DIV(TD), .GAP_TICKS(GT), .NUM_SONGS(4), .STEP_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .play_en(play_en), .song_select(song_select),
    .rom_addr(rom_addr), .rom_data(rom_data), .note_out(note_out),
    .led_out(led_out), .song_idx(song_idx), .playing(playing));

  assign rom_data = rom[rom_addr];
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int exp_led(input int n);
    return (n >= 1 && n <= 14) ? (1 << ((n - 1) % 7)) : 0;
  endfunction

  task automatic build();
    logic [7:0] e;
    q.delete();
    for (int s = 0; s < 32; s++) begin
      e = rom[m_song * 32 + s];
      q.push_back('{4'd0, 1'b1, 5'(s)});
      if (e[3:0] == 4'd0) return;
      repeat (int'(e[3:0]) * TD) q.push_back('{e[7:4], 1'b1, 5'(s)});
      repeat (GT * TD) q.push_back('{4'd0, 1'b1, 5'(s)});
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_e = '0;
    m_song = 0;
    m_done = 0;
    last_ply = 0;
    prev_sel = 2'b00;
  endtask

  task automatic model();
    logic [1:0] rise;
    bit chg;
    rise = song_select & ~prev_sel;
    prev_sel = song_select;
    chg = rise == 2'b01 || rise == 2'b10;
    if (rise == 2'b01) m_song = (m_song + 1) % 4;
    if (rise == 2'b10) m_song = (m_song + 3) % 4;
    if (last_ply && !play_en) q.delete();
    else if (last_ply && chg) build();
    else if (!last_ply && play_en && !m_done) build();
    exp_e = q.size() > 0 ? q.pop_front() : '0;
    if (!play_en) m_done = 0;
    else if (last_ply && !exp_e.ply) m_done = 1;
    last_ply = exp_e.ply;
  endtask

  task automatic cyc();
    @(posedge clk);
    model();
    @(negedge clk);
    chk("note", note_out, exp_e.note);
    chk("playing", playing, exp_e.ply);
    chk("song", song_idx, m_song);
    chk("addr", rom_addr, m_song * 32 + exp_e.st);
    chk("led", led_out, exp_led(exp_e.note));
  endtask

  task automatic pulse(input logic [1:0] b);
    song_select = b;
    cyc();
    song_select = 2'b00;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    play_en = 1'b0;
    song_select = 2'b00;
    for (int i = 0; i < 128; i++) rom[i] = {4'($urandom_range(0, 15)), 4'($urandom_range(1, 3))};
    rom[0] = 8'h12;
    rom[1] = 8'h31;
    rom[2] = 8'h00;
    rom[32 + $urandom_range(2, 6)] = 8'h50;
    for (int i = 96; i < 128; i++) rom[i] = {4'($urandom_range(0, 15)), 4'd1};
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_note", note_out, 0);
    chk("rst_playing", playing, 0);
    chk("rst_song", song_idx, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_led", led_out, 0);
    rst_n = 1'b1;
    play_en = 1'b1;
    repeat (40) cyc();
    play_en = 1'b0;
    cyc();
    pulse(2'b10);
    chk("wrap_prev", song_idx, 3);
    chk("wrap_addr", rom_addr, 'h60);
    pulse(2'b01);
    pulse(2'b01);
    chk("wrap_next", song_idx, 1);
    pulse(2'b11);
    chk("both_ignored", song_idx, 1);
    pulse(2'b10);
    play_en = 1'b1;
    repeat (4) cyc();
    pulse(2'b01);
    repeat (20) cyc();
    play_en = 1'b0;
    cyc();
    chk("stop_playing", playing, 0);
    play_en = 1'b1;
    repeat (10) cyc();
    play_en = 1'b0;
    pulse(2'b01);
    pulse(2'b01);
    play_en = 1'b1;
    repeat (32 * 9 + 10) cyc();
    chk("full_end_playing", playing, 0);
    chk("full_end_addr", rom_addr, 'h60);
    play_en = 1'b0;
    pulse(2'b10);
    play_en = 1'b1;
    repeat (15) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("async_note", note_out, 0);
    chk("async_playing", playing, 0);
    chk("async_song", song_idx, 0);
    chk("async_addr", rom_addr, 0);
    chk("async_led", led_out, 0);
    play_en = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, play_en ? 149 : 19) == 0) play_en = ~play_en;
      if ($urandom_range(0, 59) == 0) song_select = 2'($urandom_range(0, 3));
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Auto-play note sequencer for the MiniPiano.
- Walks a song ROM selected by the song_select buttons and emits a timed stream of 4-bit note codes, plus a one-hot LED pattern.
- Sits directly upstream of the Buzzer, in place of live key input when auto-play is active; its note_out feeds the Buzzer note input.
- The song ROM is external and has a combinational read: rom_data is valid in the same cycle as rom_addr.

Parameters:
- TICK_DIV, 12_500_000: clk cycles per duration tick (1/8 s at 100 MHz).
- GAP_TICKS, 1: silent ticks inserted after every note.
- NUM_SONGS, 4: number of songs; song_idx wraps modulo this value.
- STEP_W, 5: step address width; maximum 2^STEP_W entries per song.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- play_en  in  1  level; high = play the selected song, low = stop
- song_select  in  2  button levels; bit0 = next song, bit1 = previous song
- rom_addr  out  2+STEP_W  {song_idx, step}
- rom_data  in  8  [7:4] note code (0 = rest), [3:0] duration in ticks (0 = end-of-song marker)
- note_out  out  4  note code to the Buzzer; 0 = silence
- led_out  out  7  one-hot note indicator
- song_idx  out  2  currently selected song
- playing  out  1  high while a song is in progress

Behaviour:
- Reset (async, rst_n low) clears everything: state IDLE, note_out=0, led_out=0, song_idx=0, step=0, rom_addr=0, playing=0, tick counter=0, button edge registers=0.
- song_select is edge-detected through one registered stage; each rising edge acts once.
  - Next: song_idx+1, wrapping NUM_SONGS-1 -> 0.
  - Previous: song_idx-1, wrapping 0 -> NUM_SONGS-1.
  - Rising edges on both bits in the same cycle are ignored.
  - Any accepted change resets step to 0. If the state is not IDLE, the sequencer aborts the current note and goes to FETCH in the next cycle, so the new song restarts immediately.
- FSM: IDLE, FETCH, PLAY, GAP.
- IDLE
  - note_out=0, playing=0.
  - play_en high -> FETCH on the next cycle.
- FETCH (exactly 1 cycle)
  - note_out=0, playing=1.
  - Latches rom_data.
  - If duration==0 -> IDLE with step=0 (end of song; no auto-restart even if play_en stays high until it is toggled low then high).
  - Otherwise -> PLAY, clearing the tick counter.
- PLAY
  - note_out=latched note; held for exactly duration*TICK_DIV cycles, then -> GAP.
- GAP
  - note_out=0 for GAP_TICKS*TICK_DIV cycles.
  - Then step increments and the state moves to FETCH.
  - If step was 2^STEP_W-1, the song ends instead: -> IDLE, step=0.
- play_en low in any non-IDLE state:
  - -> IDLE on the next cycle, with step=0.
  - note_out=0 from that same next cycle.
- Latency: play_en sampled high at edge N gives FETCH in cycle N+1 and the first note on note_out from cycle N+2.
- Tick counter: 0..TICK_DIV-1, free-running only inside PLAY/GAP, cleared on every state entry.
- led_out is combinational from note_out:
  - note 1..7 -> bit (note-1)
  - note 8..14 -> bit (note-8)
  - note 0 or 15 -> all zero
- rom_addr is always {song_idx, step}, registered.
- A rest entry (note 0, duration>0) produces silence for its duration and is not an end marker.

Test Plan:
1. Basic play (TICK_DIV=4, GAP_TICKS=1; song0 = (1,2),(3,1),(0,0)): raise play_en -> note_out=1 for 8 cycles, 0 for 4, 1 FETCH cycle of 0, 3 for 4 cycles, 0 for 4, FETCH sees end -> IDLE with playing=0. led_out=0000001 during note 1 and 0000100 during note 3.
2. Song wrap: from reset, pulse bit1 -> song_idx=3, rom_addr=0x60; pulse bit0 twice -> song_idx=1. Raise bit0 and bit1 in the same cycle -> song_idx unchanged.
3. Select mid-song: during a PLAY of song 0, pulse next -> within 2 cycles rom_addr={1,0}, one FETCH cycle, then song 1 entry 0 plays.
4. Stop mid-note: drop play_en during PLAY -> note_out=0 and playing=0 the next cycle, step=0. Re-raise play_en -> playback restarts from entry 0.
5. Full-length song: 32 entries all with duration 1 and no end marker -> after entry 31's GAP -> IDLE, rom_addr step wraps to 0.
6. Async reset mid-PLAY: assert rst_n=0 between clock edges -> all outputs 0 immediately, song_idx=0.
